// File: rtl/serial_word_deserializer_if.sv
// serial_word_deserializer_if
//   Bundles the serial input and the valid/ready parallel output of the
//   serial word deserializer.
//   Signals:
//     sin_valid      serial bit qualifier
//     sin_bit        serial data bit
//     out_valid      held word available
//     out_ready      consumer accepts word
//     out_data       assembled N-bit word
//     out_parity_err parity status, valid with out_valid
//   Modports:
//     master  the deserializer (consumes serial bits, drives the word output)
//     slave   the environment (drives serial bits, consumes words)
interface serial_word_deserializer_if #(
    parameter int N = 8
);
    logic         sin_valid;
    logic         sin_bit;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_parity_err;

    modport master (
        input  sin_valid,
        input  sin_bit,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_parity_err
    );

    modport slave (
        output sin_valid,
        output sin_bit,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_parity_err
    );
endinterface

// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer
//   Receive end of the serial word link. Collects a bit stream into N-bit
//   words (LSB-first or MSB-first) and presents each word through a single
//   holding register on a valid/ready output.
//   Optional feature macro: PARITY_CHECK_EN -- when defined, each frame
//   carries one extra even-parity bit after the data bits and
//   out_parity_err reports ^{data, parity_bit}; otherwise out_parity_err is 0.
//   Ports:
//     clk      in   rising-edge clock
//     reset_n  in   synchronous reset, active-low (priority over clear)
//     enable   in   1 = accept serial bits, 0 = freeze frame assembly
//     clear    in   synchronous clear: abort frame, drop held word
//     dir      in   0 = LSB-first (bit enters MSB), 1 = MSB-first (bit enters LSB)
//     bus      master modport: sin_valid/sin_bit in, out_valid/out_ready/
//              out_data/out_parity_err handshake out
//     overrun  out  one-cycle pulse when a completed word is dropped
//     busy     out  frame in progress
module serial_word_deserializer #(
    parameter int N = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       clear,
    input  logic                       dir,
    serial_word_deserializer_if.master bus,
    output logic                       overrun,
    output logic                       busy
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef PARITY_CHECK_EN
    localparam logic [1:0] ST_PAR   = 2'd2;
`endif

    logic [1:0]    state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [N-1:0]  sreg_q, sreg_nxt, sreg_shift;
    logic          dir_q;
    logic          shift_dir;
    logic          bit_acc;
    logic          complete;
    logic [N-1:0]  word;
    logic          perr_new;
    logic          valid_q;
    logic [N-1:0]  data_q;
    logic          perr_q;
    logic          overrun_q;

    always_comb begin
        bit_acc    = enable & bus.sin_valid;
        // Direction is captured with the first bit; later bits use the held copy.
        shift_dir  = (state_q == ST_IDLE) ? dir : dir_q;
        sreg_shift = shift_dir ? {sreg_q[N-2:0], bus.sin_bit}
                               : {bus.sin_bit, sreg_q[N-1:1]};
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        sreg_nxt   = sreg_q;
        complete   = 1'b0;
        word       = sreg_shift;
        perr_new   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bit_acc) begin
                    sreg_nxt  = sreg_shift;
                    cnt_nxt   = CW'(1);
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_acc) begin
                    sreg_nxt = sreg_shift;
                    if (cnt_q == LAST_CNT) begin
                        cnt_nxt = '0;
`ifdef PARITY_CHECK_EN
                        state_nxt = ST_PAR;
`else
                        state_nxt = ST_IDLE;
                        complete  = 1'b1;
`endif
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            ST_PAR: begin
                // Parity bit is not shifted in; the data word is already complete.
                if (bit_acc) begin
                    complete  = 1'b1;
                    word      = sreg_q;
                    perr_new  = ^{sreg_q, bus.sin_bit};
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sreg_q    <= '0;
            dir_q     <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            sreg_q    <= sreg_nxt;
            overrun_q <= 1'b0;
            if (state_q == ST_IDLE && bit_acc) begin
                dir_q <= dir;
            end
            // Single holding register: a completing word is taken only if the
            // register is empty or is being emptied on this same edge.
            if (complete) begin
                if (!valid_q || bus.out_ready) begin
                    data_q  <= word;
                    perr_q  <= perr_new;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_data       = data_q;
    assign bus.out_parity_err = perr_q;
    assign overrun            = overrun_q;
    assign busy               = (state_q != ST_IDLE);
endmodule
